// File: rtl/invader_formation.sv
// Invader formation controller: kill handling, timed marching, edge reversal and drop,
// with outputs published once per video frame from an internal working copy.
module invader_formation #(
   parameter int         ROWS        = 5,
   parameter int         COLS        = 11,
   parameter logic [9:0] START_X     = 10'd40,
   parameter logic [9:0] START_Y     = 10'd60,
   parameter int         PITCH_X     = 16,
   parameter int         PITCH_Y     = 16,
   parameter int         INV_W       = 12,
   parameter int         INV_H       = 8,
   parameter int         STEP_X      = 2,
   parameter int         STEP_Y      = 8,
   parameter int         LEFT_BOUND  = 8,
   parameter int         RIGHT_BOUND = 632,
   parameter int         BOTTOM_Y    = 440,
   parameter int         MIN_PERIOD  = 2,
   localparam int        N           = ROWS * COLS,
   localparam int        IW          = $clog2(N),
   localparam int        CW          = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame,
   input  logic          start,
   input  logic          kill_valid,
   input  logic [IW-1:0] kill_idx,
   output logic [N-1:0]  alive,
   output logic [9:0]    form_x,
   output logic [9:0]    form_y,
   output logic          dir_left,
   output logic [CW-1:0] alive_count,
   output logic [1:0]    state,
   output logic          moved
);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_RUN     = 2'b01;
   localparam logic [1:0] S_LANDED  = 2'b10;
   localparam logic [1:0] S_CLEARED = 2'b11;

   localparam logic [15:0] N16    = 16'(N);
   localparam logic [15:0] PX16   = 16'(PITCH_X);
   localparam logic [15:0] PY16   = 16'(PITCH_Y);
   localparam logic [15:0] INVW16 = 16'(INV_W);
   localparam logic [15:0] INVH16 = 16'(INV_H);
   localparam logic [15:0] SX16   = 16'(STEP_X);
   localparam logic [15:0] LB16   = 16'(LEFT_BOUND);
   localparam logic [15:0] RB16   = 16'(RIGHT_BOUND);
   localparam logic [15:0] BY16   = 16'(BOTTOM_Y);
   localparam logic [15:0] MINP16 = 16'(MIN_PERIOD);
   localparam logic [9:0]  SX10   = 10'(STEP_X);
   localparam logic [9:0]  SY10   = 10'(STEP_Y);

   logic [N-1:0]    w_mask, k_mask, n_mask;
   logic [9:0]      w_x, w_y, n_x, n_y;
   logic            w_dir, n_dir;
   logic [CW-1:0]   w_count, k_count, n_count;
   logic [1:0]      w_st, n_st;
   logic [15:0]     fcnt, n_fcnt, period;
   logic            n_moved, kill_hit, lc_found, right_hit, left_hit;
   logic [COLS-1:0] col_any;
   logic [ROWS-1:0] row_any;
   logic [15:0]     lc, rc, br;

   // Kill is applied first so edges, bottom row and period see the post-kill formation.
   always_comb begin
      kill_hit = 1'b0;
      if (w_st == S_RUN && kill_valid && !start && (16'(kill_idx) < N16))
         kill_hit = w_mask[kill_idx];
      k_mask  = w_mask;
      k_count = w_count;
      if (kill_hit) begin
         k_mask[kill_idx] = 1'b0;
         k_count          = w_count - CW'(1);
      end

      col_any = '0;
      row_any = '0;
      for (int unsigned r = 0; r < ROWS; r++)
         for (int unsigned c = 0; c < COLS; c++)
            if (k_mask[r*COLS + c]) begin
               col_any[c] = 1'b1;
               row_any[r] = 1'b1;
            end

      lc       = '0;
      rc       = '0;
      br       = '0;
      lc_found = 1'b0;
      for (int unsigned c = 0; c < COLS; c++)
         if (col_any[c]) begin
            rc = 16'(c);
            if (!lc_found) begin
               lc       = 16'(c);
               lc_found = 1'b1;
            end
         end
      for (int unsigned r = 0; r < ROWS; r++)
         if (row_any[r]) br = 16'(r);

      right_hit = (16'(w_x) + rc * PX16 + INVW16 + SX16) > RB16;
      left_hit  = (16'(w_x) + lc * PX16) < (LB16 + SX16);
      period    = (16'(k_count) > MINP16) ? 16'(k_count) : MINP16;
   end

   always_comb begin
      n_mask  = k_mask;
      n_count = k_count;
      n_x     = w_x;
      n_y     = w_y;
      n_dir   = w_dir;
      n_st    = w_st;
      n_fcnt  = fcnt;
      n_moved = 1'b0;
      if (start) begin
         n_mask  = '1;
         n_count = CW'(N);
         n_x     = START_X;
         n_y     = START_Y;
         n_dir   = 1'b0;
         n_st    = S_RUN;
         n_fcnt  = '0;
      end else if (w_st == S_RUN) begin
         if (k_count == '0) begin
            n_st = S_CLEARED;
         end else if (frame) begin
            // >= rather than == so a period shrunk by kills still triggers
            if (fcnt >= period - 16'd1) begin
               n_fcnt  = '0;
               n_moved = 1'b1;
               if (w_dir ? left_hit : right_hit) begin
                  n_y   = w_y + SY10;
                  n_dir = ~w_dir;
                  if ((16'(n_y) + br * PY16 + INVH16) >= BY16)
                     n_st = S_LANDED;
               end else if (w_dir) begin
                  n_x = (w_x >= SX10) ? (w_x - SX10) : '0;
               end else begin
                  n_x = w_x + SX10;
               end
            end else begin
               n_fcnt = fcnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_mask      <= '0;
         w_x         <= START_X;
         w_y         <= START_Y;
         w_dir       <= 1'b0;
         w_count     <= '0;
         w_st        <= S_IDLE;
         fcnt        <= '0;
         alive       <= '0;
         form_x      <= START_X;
         form_y      <= START_Y;
         dir_left    <= 1'b0;
         alive_count <= '0;
         state       <= S_IDLE;
         moved       <= 1'b0;
      end else begin
         w_mask  <= n_mask;
         w_x     <= n_x;
         w_y     <= n_y;
         w_dir   <= n_dir;
         w_count <= n_count;
         w_st    <= n_st;
         fcnt    <= n_fcnt;
         moved   <= n_moved;
         if (frame) begin
            alive       <= n_mask;
            form_x      <= n_x;
            form_y      <= n_y;
            dir_left    <= n_dir;
            alive_count <= n_count;
            state       <= n_st;
         end
      end
   end

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: a vector table for the basic kill/publish behaviour
// plus hand-written marching, reversal, clear, landing and reset sequences.
module tb_invader_formation;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame, start, kill_valid;
   logic [5:0]  kill_idx;
   logic [54:0] alive;
   logic [9:0]  form_x, form_y;
   logic        dir_left;
   logic [5:0]  alive_count;
   logic [1:0]  state;
   logic        moved;

   int passed = 0;
   int total  = 0;

   invader_formation dut (
      .clk(clk), .rst_n(rst_n), .frame(frame), .start(start),
      .kill_valid(kill_valid), .kill_idx(kill_idx), .alive(alive),
      .form_x(form_x), .form_y(form_y), .dir_left(dir_left),
      .alive_count(alive_count), .state(state), .moved(moved)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        f, s, kv;
      logic [5:0]  ki;
      logic [54:0] e_alive;
      logic [5:0]  e_cnt;
      logic [9:0]  e_x, e_y;
      logic        e_dir;
      logic [1:0]  e_st;
      logic        e_mv;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step(input logic f, input logic s, input logic kv, input logic [5:0] ki);
      frame = f; start = s; kill_valid = kv; kill_idx = ki;
      @(posedge clk);
      #1;
      frame = 1'b0; start = 1'b0; kill_valid = 1'b0; kill_idx = '0;
   endtask

   task automatic kill_except(input int a, input int b);
      for (int i = 0; i < 55; i++)
         if (i != a && i != b) step(1'b0, 1'b0, 1'b1, 6'(i));
   endtask

   logic [54:0] all1, no0, no54, m;
   int mv, n;
   logic exp_mv;

   initial begin
      all1 = '1;
      no0  = all1; no0[0]   = 1'b0;
      no54 = all1; no54[54] = 1'b0;
      //          f     s     kv    ki     alive  cnt    x       y       dir   st     mv
      vt[0] = '{1'b0, 1'b1, 1'b0, 6'd0,  '0,    6'd0,  10'd40, 10'd60, 1'b0, 2'b00, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 6'd0,  all1,  6'd55, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 6'd0,  all1,  6'd55, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[3] = '{1'b0, 1'b0, 1'b1, 6'd0,  all1,  6'd55, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1'b1, 6'd55, all1,  6'd55, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[5] = '{1'b1, 1'b0, 1'b0, 6'd0,  no0,   6'd54, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[6] = '{1'b0, 1'b1, 1'b1, 6'd1,  no0,   6'd54, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[7] = '{1'b1, 1'b0, 1'b0, 6'd0,  all1,  6'd55, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};
      vt[8] = '{1'b1, 1'b0, 1'b1, 6'd54, no54,  6'd54, 10'd40, 10'd60, 1'b0, 2'b01, 1'b0};

      frame = 0; start = 0; kill_valid = 0; kill_idx = '0;
      rst_n = 1'b0;
      #12;
      chk("rst.alive", 64'(alive), 64'd0);
      chk("rst.x", 64'(form_x), 64'd40);
      chk("rst.y", 64'(form_y), 64'd60);
      chk("rst.dir", 64'(dir_left), 64'd0);
      chk("rst.cnt", 64'(alive_count), 64'd0);
      chk("rst.state", 64'(state), 64'd0);
      chk("rst.moved", 64'(moved), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         step(vt[i].f, vt[i].s, vt[i].kv, vt[i].ki);
         chk($sformatf("v%0d.alive", i), 64'(alive), 64'(vt[i].e_alive));
         chk($sformatf("v%0d.cnt", i), 64'(alive_count), 64'(vt[i].e_cnt));
         chk($sformatf("v%0d.x", i), 64'(form_x), 64'(vt[i].e_x));
         chk($sformatf("v%0d.y", i), 64'(form_y), 64'(vt[i].e_y));
         chk($sformatf("v%0d.dir", i), 64'(dir_left), 64'(vt[i].e_dir));
         chk($sformatf("v%0d.state", i), 64'(state), 64'(vt[i].e_st));
         chk($sformatf("v%0d.moved", i), 64'(moved), 64'(vt[i].e_mv));
      end

      // Full formation: period 55, first step on the 55th frame.
      step(0, 1, 0, 0);
      mv = 0;
      for (int i = 0; i < 54; i++) begin
         step(1, 0, 0, 0);
         if (moved) mv++;
      end
      chk("p55.no_early_move", 64'(mv), 64'd0);
      chk("p55.x_before", 64'(form_x), 64'd40);
      step(1, 0, 0, 0);
      chk("p55.moved", 64'(moved), 64'd1);
      chk("p55.x_after", 64'(form_x), 64'd42);
      step(0, 0, 0, 0);
      chk("p55.moved_pulse", 64'(moved), 64'd0);

      // Column 10 empty: right reversal at x=476 (rc=9) rather than 460.
      step(0, 1, 0, 0);
      kill_except(0, 9);
      step(1, 0, 0, 0);
      m = '0; m[0] = 1'b1; m[9] = 1'b1;
      chk("rc9.cnt", 64'(alive_count), 64'd2);
      chk("rc9.alive", 64'(alive), 64'(m));
      mv = 0; n = 0;
      while (!dir_left && n < 2000) begin
         step(1, 0, 0, 0);
         if (moved) mv++;
         n++;
      end
      chk("rc9.dir", 64'(dir_left), 64'd1);
      chk("rc9.x", 64'(form_x), 64'd476);
      chk("rc9.y", 64'(form_y), 64'd68);
      chk("rc9.moves", 64'(mv), 64'd219);

      // Kill on a move frame: rc shrinks 10->9 so x=460 steps instead of dropping.
      step(0, 1, 0, 0);
      kill_except(9, 10);
      step(1, 0, 0, 0);
      n = 0;
      while (form_x != 10'd460 && n < 1000) begin
         step(1, 0, 0, 0);
         n++;
      end
      chk("kmv.reach460", 64'(form_x), 64'd460);
      step(1, 0, 0, 0);
      chk("kmv.idle_frame", 64'(moved), 64'd0);
      step(1, 0, 1, 10);
      m = '0; m[9] = 1'b1;
      chk("kmv.x", 64'(form_x), 64'd462);
      chk("kmv.y", 64'(form_y), 64'd60);
      chk("kmv.dir", 64'(dir_left), 64'd0);
      chk("kmv.cnt", 64'(alive_count), 64'd1);
      chk("kmv.alive", 64'(alive), 64'(m));
      chk("kmv.moved", 64'(moved), 64'd1);

      // Single survivor: period MIN_PERIOD; final kill on a move frame clears without moving.
      step(0, 1, 0, 0);
      kill_except(30, 30);
      for (int i = 1; i <= 7; i++) begin
         step(1, 0, 0, 0);
         exp_mv = (i % 2 == 0);
         chk($sformatf("p2.f%0d.moved", i), 64'(moved), 64'(exp_mv));
      end
      chk("p2.x", 64'(form_x), 64'd46);
      step(1, 0, 1, 30);
      chk("clr.state", 64'(state), 64'd3);
      chk("clr.cnt", 64'(alive_count), 64'd0);
      chk("clr.alive", 64'(alive), 64'd0);
      chk("clr.x", 64'(form_x), 64'd46);
      chk("clr.moved", 64'(moved), 64'd0);
      mv = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0);
         if (moved) mv++;
      end
      chk("clr.no_moves", 64'(mv), 64'd0);
      chk("clr.x_hold", 64'(form_x), 64'd46);

      // Bottom row 4 alive, cols 0 and 10: lands on the 39th drop at y=372, right edge.
      step(0, 1, 0, 0);
      kill_except(44, 54);
      n = 0;
      while (state != 2'b10 && n < 40000) begin
         step(1, 0, 0, 0);
         n++;
      end
      chk("land.state", 64'(state), 64'd2);
      chk("land.y", 64'(form_y), 64'd372);
      chk("land.x", 64'(form_x), 64'd460);
      chk("land.dir", 64'(dir_left), 64'd1);
      chk("land.moved", 64'(moved), 64'd1);
      mv = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0);
         if (moved) mv++;
      end
      chk("land.no_moves", 64'(mv), 64'd0);
      chk("land.y_hold", 64'(form_y), 64'd372);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      chk("restart.state", 64'(state), 64'd1);
      chk("restart.x", 64'(form_x), 64'd40);
      chk("restart.y", 64'(form_y), 64'd60);
      chk("restart.cnt", 64'(alive_count), 64'd55);
      chk("restart.dir", 64'(dir_left), 64'd0);

      // Asynchronous reset in the middle of a kill + frame cycle.
      frame = 1'b1; kill_valid = 1'b1; kill_idx = 6'd5;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.state", 64'(state), 64'd0);
      chk("arst.alive", 64'(alive), 64'd0);
      chk("arst.cnt", 64'(alive_count), 64'd0);
      chk("arst.x", 64'(form_x), 64'd40);
      frame = 1'b0; kill_valid = 1'b0; kill_idx = '0;
      @(negedge clk) rst_n = 1'b1;
      mv = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 6'(i));
         if (moved) mv++;
      end
      chk("arst.idle_state", 64'(state), 64'd0);
      chk("arst.idle_cnt", 64'(alive_count), 64'd0);
      chk("arst.idle_moves", 64'(mv), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/invader_formation.md
INVADER_FORMATION -- requirements
Module: invader_formation

Interface
REQ-001 Parameter ROWS, default 5: formation rows.
REQ-002 Parameter COLS, default 11: formation columns; N = ROWS*COLS.
REQ-003 Parameter START_X / START_Y, defaults 10'd40 / 10'd60: formation origin at load, in pixels.
REQ-004 Parameter PITCH_X / PITCH_Y, defaults 16 / 16: column and row spacing.
REQ-005 Parameter INV_W / INV_H, defaults 12 / 8: single invader size.
REQ-006 Parameter STEP_X / STEP_Y, defaults 2 / 8: horizontal step per move and drop per reversal.
REQ-007 Parameter LEFT_BOUND / RIGHT_BOUND / BOTTOM_Y, defaults 8 / 632 / 440: playfield limits.
REQ-008 Parameter MIN_PERIOD, default 2: minimum frames between moves.
REQ-009 clk  in  1  system clock; all state changes on its rising edge.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 frame  in  1  one-cycle pulse, once per video frame.
REQ-012 start  in  1  one-cycle pulse: load formation and begin play.
REQ-013 kill_valid  in  1  kill request qualifier.
REQ-014 kill_idx  in  $clog2(N)  invader index = row*COLS+col; row 0 is the top row.
REQ-015 alive  out  N  published alive mask; bit i = invader i.
REQ-016 form_x / form_y  out  10 each  published formation origin.
REQ-017 dir_left  out  1  published direction: 1 = moving left.
REQ-018 alive_count  out  $clog2(N+1)  published alive count.
REQ-019 state  out  2  00 IDLE, 01 RUN, 10 LANDED, 11 CLEARED.
REQ-020 moved  out  1  one-cycle pulse on a frame cycle in which a move or drop occurred.

Function
REQ-021 Working copies of mask, x, y, dir and count shall be updated internally; published outputs shall update only on frame cycles, taking the working values after that cycle's kill and move.
REQ-022 IDLE: no movement, kills ignored; start -> RUN with mask all ones, x=START_X, y=START_Y, dir right, count N, frame counter 0.
REQ-023 RUN, kill_valid with kill_idx<N and bit set: clear the bit and decrement count next cycle; if out of range or already dead, no effect.
REQ-024 RUN frame cycle: frame counter increments; when it reaches period-1 it wraps to 0 and a move occurs, where period = max(MIN_PERIOD, count).
REQ-025 Edges use only columns with at least one alive invader: lc = leftmost, rc = rightmost alive column.
REQ-026 Moving right, if x+rc*PITCH_X+INV_W+STEP_X > RIGHT_BOUND, the move is a drop: y += STEP_Y, dir flips, x unchanged; otherwise x += STEP_X.
REQ-027 Moving left, if x+lc*PITCH_X < LEFT_BOUND+STEP_X, the move is a drop; otherwise x -= STEP_X.
REQ-028 Edge arithmetic shall use at least 12-bit unsigned intermediates with no wrap; x and y shall never underflow.
REQ-029 Kill and move in the same cycle: the kill applies first, and edges and period use the post-kill mask and count.
REQ-030 RUN -> CLEARED when count becomes 0; this takes priority over a move in the same cycle; CLEARED shall publish on the next frame.
REQ-031 RUN -> LANDED when, after a drop, y+br*PITCH_Y+INV_H >= BOTTOM_Y, where br = bottom alive row; movement then stops.
REQ-032 start in any state reloads the formation and enters RUN; start together with kill_valid: the kill is ignored.
REQ-033 moved shall pulse only in RUN, on the frame cycle of a step or drop.

Reset
REQ-034 rst_n low, asynchronous: state IDLE; working and published mask = 0; form_x = START_X; form_y = START_Y; dir_left = 0; alive_count = 0; frame counter 0; moved = 0.
REQ-035 Reset asserted mid-move or mid-kill shall abort the operation with no partial update; after release the block waits in IDLE for start.

Verification
REQ-036 Reset, start, then 2 frames with default parameters: alive = all 55 ones, form_x = 40 -> form_x = 42 after 55 frames (period 55), moved pulses once.
REQ-037 Kill idx 0 then idx 0 again: alive_count 54 published on next frame; the second kill has no effect; kill idx 55 is ignored.
REQ-038 Kill all of column 10, then run right to the boundary: reversal uses rc = 9; form_y += 8 and dir_left = 1 on the drop frame, with x unchanged.
REQ-039 Kill 54 invaders, leaving idx 30: period = MIN_PERIOD = 2, so a move every 2nd frame; kill idx 30 -> state CLEARED, no further moves.
REQ-040 Force drops until the bottom is reached: state LANDED, form_y frozen; start -> RUN with reloaded origin 40/60.
REQ-041 Kill_valid asserted on the same cycle as a move frame: the post-kill edge is used, and both effects are published that frame.
